// File: rtl/layer_argmax.sv
// layer_argmax: output-layer argmax for the digit-detection network.
// Accepts N_CLASSES signed scores one per handshake, keeps the running
// signed maximum (ties keep the lower index), mirrors every score into a
// readback buffer, and presents the winning index and score on a
// valid/ready result port.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for start; no input or output handshakes
// S_ACCUM | accepting scores, tracking the running maximum
// S_DONE  | result held on out_class/out_value until out_ready
module layer_argmax #(
   parameter int N_CLASSES = 10,
   parameter int DATA_W    = 32,
   parameter int IDX_W     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  out_class,
   output logic [DATA_W-1:0] out_value,
   output logic              busy,
   input  logic [IDX_W-1:0]  rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t            r_state;
   logic [IDX_W-1:0]  r_cnt;
   logic [IDX_W-1:0]  r_class;
   logic [DATA_W-1:0] r_value;
   logic [DATA_W-1:0] r_buf [N_CLASSES];
   logic [DATA_W-1:0] r_rd_data;

   logic w_accept;
   logic w_last;
   logic w_first;
   logic w_greater;
   logic w_rd_in_range;

   // Handshake and compare decode; in_ready depends only on registered state.
   assign in_ready      = (r_state == S_ACCUM);
   assign out_valid     = (r_state == S_DONE);
   assign busy          = (r_state != S_IDLE);
   assign w_accept      = in_valid && in_ready;
   assign w_first       = (r_cnt == '0);
   assign w_last        = (r_cnt == IDX_W'(N_CLASSES - 1));
   assign w_greater     = ($signed(in_data) > $signed(r_value));
   assign w_rd_in_range = (int'(rd_addr) < N_CLASSES);

   assign out_class = r_class;
   assign out_value = r_value;
   assign rd_data   = r_rd_data;

   // Sequencer, running maximum and score buffer writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_class <= '0;
         r_value <= '0;
         for (int i = 0; i < N_CLASSES; i++) begin
            r_buf[i] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_ACCUM;
                  r_cnt   <= '0;
                  r_class <= '0;
                  r_value <= '0;
               end
            end
            S_ACCUM: begin
               if (w_accept) begin
                  r_buf[r_cnt] <= in_data;
                  r_cnt        <= r_cnt + 1'b1;
                  // Strict compare: an equal later score never displaces
                  // the earlier index.
                  if (w_first || w_greater) begin
                     r_value <= in_data;
                     r_class <= r_cnt;
                  end
                  if (w_last) begin
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  if (start) begin
                     r_state <= S_ACCUM;
                     r_cnt   <= '0;
                     r_class <= '0;
                     r_value <= '0;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Registered readback; a same-cycle write is seen on the following read.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_data <= '0;
      end else if (w_rd_in_range) begin
         r_rd_data <= r_buf[rd_addr];
      end else begin
         r_rd_data <= '0;
      end
   end

endmodule
